// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program
// counter, presents it to instruction memory, picks the next PC from one of
// four sources and registers the returned word, with its PC, into the IF/ID
// pipeline register for decode. A fetch from an unaligned or out-of-range
// address is tagged as a fault: the word is replaced by zero and exc_D is set.
// The faulting PC still advances normally; redirecting on the fault is CP0's
// job.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC and IF/ID (hazard unit)
//   flush_D        clear IF/ID to a bubble at the next edge
//   npc_sel        next-PC source: 00 PC+4, 01 branch, 10 jump, 11 jr
//   branch_target  branch target computed in decode
//   jump_index     instr_index field of J/JAL in decode
//   jr_target      forwarded rs value for JR/JALR
//   instr_F        word returned combinationally by instruction memory for PC_F
//   PC_F           current fetch address
//   instr_D        IF/ID instruction
//   PC_D           IF/ID PC
//   PC8_D          PC_D + 8, the link address
//   valid_D        IF/ID holds a real instruction
//   exc_D          IF/ID instruction had a fetch-address fault
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_D,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic        exc_D
);

  // First byte address past the end of instruction memory. Held in 33 bits so
  // a memory that ends exactly at the top of the address space does not wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'd4 << IM_AW);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_t;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] npc;
  logic        fault_F;

  logic [31:0] instr_q;
  logic [31:0] pc_d_q;
  logic [31:0] pc8_d_q;
  logic        valid_q;
  logic        exc_q;

  // Sequential and link addresses; both wrap modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // Next-PC mux. Only decode-stage operands and the PC itself feed it, so
  // there is no combinational path from instr_F back to PC_F.
  always_comb begin
    npc = pc_plus4;
    case (npc_sel_t'(npc_sel))
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = branch_target;
      NPC_JUMP:   npc = {pc_q[31:28], jump_index, 2'b00};
      NPC_JR:     npc = jr_target;
      default:    npc = pc_plus4;
    endcase
  end

  // A fetch faults when it is not word aligned or falls outside the window
  // of instruction memory.
  assign fault_F = (pc_q[1:0] != 2'b00) ||
                   (pc_q < RESET_PC) ||
                   ({1'b0, pc_q} >= PC_LIMIT);

  // Program counter. Stall freezes it; flush only affects IF/ID, so the
  // delay-slot instruction keeps flowing and the PC still follows npc_sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= npc;
    end
  end

  // IF/ID pipeline register. Flush wins over stall so the hazard unit can
  // turn a held slot into a bubble. A faulting fetch is latched with a zeroed
  // instruction so decode never acts on whatever memory returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc_d_q  <= 32'd0;
      pc8_d_q <= 32'd0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (flush_D) begin
      instr_q <= 32'd0;
      pc_d_q  <= 32'd0;
      pc8_d_q <= 32'd0;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (!stall) begin
      instr_q <= fault_F ? 32'd0 : instr_F;
      pc_d_q  <= pc_q;
      pc8_d_q <= pc_plus8;
      valid_q <= 1'b1;
      exc_q   <= fault_F;
    end
  end

  assign PC_F    = pc_q;
  assign instr_D = instr_q;
  assign PC_D    = pc_d_q;
  assign PC8_D   = pc8_d_q;
  assign valid_D = valid_q;
  assign exc_D   = exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// --------------
// Drives fetch_stage through a table of per-cycle vectors, checks PC_F after
// every edge against the table, and checks the IF/ID register against a
// queue of expected entries pushed when each vector is applied. A few
// hand-written sequences cover reset, async reset and restart.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush_D;
  logic [1:0]  npc_sel;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] instr_F;
  logic [31:0] PC_F;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;
  logic        exc_D;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        exc;
  } ifid_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  sel;
    logic [31:0] target;
    logic [25:0] jidx;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t  vecs[$];
  ifid_t sb[$];
  ifid_t last_exp;
  logic [31:0] exp_pc_cur;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush_D(flush_D),
    .npc_sel(npc_sel),
    .branch_target(branch_target),
    .jump_index(jump_index),
    .jr_target(jr_target),
    .instr_F(instr_F),
    .PC_F(PC_F),
    .instr_D(instr_D),
    .PC_D(PC_D),
    .PC8_D(PC8_D),
    .valid_D(valid_D),
    .exc_D(exc_D)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a distinct, address-dependent word everywhere.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return pc ^ 32'h2400_0000;
  endfunction

  assign instr_F = mem_word(PC_F);

  // Valid fetch window for the default parameters: 0x3000 .. 0x3FFC.
  function automatic logic fault_of(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_4000);
  endfunction

  function automatic vec_t mk(input logic s, input logic f, input logic [1:0] sel,
                              input logic [31:0] tgt, input logic [25:0] jidx,
                              input logic [31:0] exp_pc);
    vec_t v;
    v.stall = s;
    v.flush = f;
    v.sel = sel;
    v.target = tgt;
    v.jidx = jidx;
    v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one vector and push the IF/ID content it should produce.
  task automatic applyStimulus(input vec_t v);
    ifid_t e;
    stall = v.stall;
    flush_D = v.flush;
    npc_sel = v.sel;
    branch_target = (v.sel == 2'b01) ? v.target : 32'hDEAD_0000;
    jr_target = (v.sel == 2'b11) ? v.target : 32'hBEEF_0000;
    jump_index = v.jidx;
    if (v.flush) begin
      e = '0;
    end else if (v.stall) begin
      e = last_exp;
    end else begin
      e.pc = exp_pc_cur;
      e.pc8 = exp_pc_cur + 32'd8;
      e.valid = 1'b1;
      e.exc = fault_of(exp_pc_cur);
      e.instr = e.exc ? 32'd0 : mem_word(exp_pc_cur);
    end
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic checkIfid(input string tag);
    ifid_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, " PC_D"}, PC_D, e.pc);
      checkOutput({tag, " PC8_D"}, PC8_D, e.pc8);
      checkOutput({tag, " instr_D"}, instr_D, e.instr);
      checkOutput({tag, " valid_D"}, {31'd0, valid_D}, {31'd0, e.valid});
      checkOutput({tag, " exc_D"}, {31'd0, exc_D}, {31'd0, e.exc});
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush_D = 1'b0;
    npc_sel = 2'b00;
    branch_target = 32'd0;
    jump_index = 26'd0;
    jr_target = 32'd0;
    last_exp = '0;
    exp_pc_cur = 32'h0000_3000;

    // stall, flush, sel, target, jump_index, expected PC_F after the edge
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3004));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_300C));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3010));
    vecs.push_back(mk(1, 0, 2'b01, 32'h0000_3100, 26'h0, 32'h0000_3010));
    vecs.push_back(mk(1, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3010));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3014));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3018));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_301C));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3020));
    vecs.push_back(mk(0, 0, 2'b01, 32'h0000_3040, 26'h0, 32'h0000_3040));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3044));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0, 26'h000_0C10, 32'h0000_3040));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_3002, 26'h0, 32'h0000_3002));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_3006));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_300A));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_4000, 26'h0, 32'h0000_4000));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_4004));
    vecs.push_back(mk(1, 1, 2'b00, 32'h0, 26'h0, 32'h0000_4004));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_2FFC, 26'h0, 32'h0000_2FFC));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_3FFC, 26'h0, 32'h0000_3FFC));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_4000));
    vecs.push_back(mk(0, 0, 2'b11, 32'hFFFF_FFF8, 26'h0, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0, 26'h0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 2'b11, 32'hF000_0000, 26'h0, 32'hF000_0000));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0, 26'h000_0C10, 32'hF000_3040));
    vecs.push_back(mk(0, 1, 2'b00, 32'h0, 26'h0, 32'hF000_3044));
    vecs.push_back(mk(0, 0, 2'b11, 32'h0000_3050, 26'h0, 32'h0000_3050));

    // Reset held for three cycles: everything at its reset value.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset PC_F", PC_F, 32'h0000_3000);
    checkOutput("reset PC_D", PC_D, 32'd0);
    checkOutput("reset PC8_D", PC8_D, 32'd0);
    checkOutput("reset instr_D", instr_D, 32'd0);
    checkOutput("reset valid_D", {31'd0, valid_D}, 32'd0);
    checkOutput("reset exc_D", {31'd0, exc_D}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d PC_F", i), PC_F, vecs[i].exp_pc);
      checkIfid($sformatf("vec%0d", i));
      exp_pc_cur = vecs[i].exp_pc;
    end

    // Asynchronous reset between edges at PC_F = 0x3050.
    stall = 1'b0;
    flush_D = 1'b0;
    npc_sel = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async PC_F", PC_F, 32'h0000_3000);
    checkOutput("async valid_D", {31'd0, valid_D}, 32'd0);
    checkOutput("async PC_D", PC_D, 32'd0);
    checkOutput("async instr_D", instr_D, 32'd0);

    // Release: the first edge with reset low fetches RESET_PC.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("held PC_F", PC_F, 32'h0000_3000);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart PC_F", PC_F, 32'h0000_3004);
    checkOutput("restart PC_D", PC_D, 32'h0000_3000);
    checkOutput("restart PC8_D", PC8_D, 32'h0000_3008);
    checkOutput("restart instr_D", instr_D, mem_word(32'h0000_3000));
    checkOutput("restart valid_D", {31'd0, valid_D}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
